// File: rtl/transmisor_adc_din_if.sv
// Touch-panel ADC link bundle: frame request, pen-down input, serial link and frame status.
// The transmitter drives through the master modport; a receiver or bench uses the slave modport.
interface transmisor_adc_din_if;
    logic       start_s;
    logic       penirq_n_s;
    logic       adc_cs_n_s;
    logic       adc_dclk_s;
    logic       adc_din_s;
    logic [6:0] count_80_s;
    logic       trans_en_s;
    logic       busy_s;
    logic       done_s;

    modport master (
        input  start_s,
        input  penirq_n_s,
        output adc_cs_n_s,
        output adc_dclk_s,
        output adc_din_s,
        output count_80_s,
        output trans_en_s,
        output busy_s,
        output done_s
    );

    modport slave (
        output start_s,
        output penirq_n_s,
        input  adc_cs_n_s,
        input  adc_dclk_s,
        input  adc_din_s,
        input  count_80_s,
        input  trans_en_s,
        input  busy_s,
        input  done_s
    );
endinterface

// File: rtl/transmisor_adc_din.sv
// Touch-panel ADC serial master: one 80-step frame per request, shifting the X and Y control
// bytes out on DIN while DCLK follows bit 0 of the frame step counter.
module transmisor_adc_din #(
    parameter int         CLK_DIV  = 16,
    parameter logic [7:0] CMD_X    = 8'h92,
    parameter logic [7:0] CMD_Y    = 8'hD2,
    parameter bit         PEN_GATE = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    transmisor_adc_din_if.master  adc_if
);

    localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [6:0]     LAST_STEP  = 7'd79;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   presc_r, presc_s;
    logic [6:0]      count_r, count_s;
    logic            cs_n_r, cs_n_s;
    logic            dclk_r, dclk_s;
    logic            din_r, din_s;
    logic            trans_en_r, trans_en_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            req_ok_s;

    // Steps 0..15 carry CMD_X and 32..47 carry CMD_Y, one bit per even/odd pair, MSB first;
    // in both windows the bit index is 7 - c[3:1], i.e. ~c[3:1].
    function automatic logic din_bit(input logic [6:0] c);
        logic [2:0] idx;
        idx = ~c[3:1];
        if (c < 7'd16) begin
            din_bit = CMD_X[idx];
        end else if ((c >= 7'd32) && (c < 7'd48)) begin
            din_bit = CMD_Y[idx];
        end else begin
            din_bit = 1'b0;
        end
    endfunction

    // Next state, prescaler and step counter; outputs are derived from the next values so the
    // registered outputs change on the same edge as the step counter.
    always_comb begin
        state_s  = state_r;
        presc_s  = presc_r;
        count_s  = count_r;
        req_ok_s = adc_if.start_s & (~PEN_GATE | ~adc_if.penirq_n_s);
        case (state_r)
            ST_IDLE: begin
                presc_s = '0;
                count_s = 7'd0;
                if (req_ok_s) begin
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (presc_r == PRESC_LAST) begin
                    presc_s = '0;
                    if (count_r >= LAST_STEP) begin
                        state_s = ST_DONE;
                        count_s = 7'd0;
                    end else begin
                        count_s = count_r + 7'd1;
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                presc_s = '0;
                count_s = 7'd0;
            end
            default: begin
                state_s = ST_IDLE;
                presc_s = '0;
                count_s = 7'd0;
            end
        endcase

        cs_n_s     = (state_s != ST_XFER);
        trans_en_s = (state_s == ST_XFER);
        busy_s     = (state_s == ST_XFER) | (state_s == ST_DONE);
        done_s     = (state_s == ST_DONE);
        if (state_s == ST_XFER) begin
            dclk_s = count_s[0];
            din_s  = din_bit(count_s);
        end else begin
            dclk_s = 1'b0;
            din_s  = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r    <= ST_IDLE;
            presc_r    <= '0;
            count_r    <= 7'd0;
            cs_n_r     <= 1'b1;
            dclk_r     <= 1'b0;
            din_r      <= 1'b0;
            trans_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            presc_r    <= presc_s;
            count_r    <= count_s;
            cs_n_r     <= cs_n_s;
            dclk_r     <= dclk_s;
            din_r      <= din_s;
            trans_en_r <= trans_en_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign adc_if.adc_cs_n_s = cs_n_r;
    assign adc_if.adc_dclk_s = dclk_r;
    assign adc_if.adc_din_s  = din_r;
    assign adc_if.count_80_s = count_r;
    assign adc_if.trans_en_s = trans_en_r;
    assign adc_if.busy_s     = busy_r;
    assign adc_if.done_s     = done_r;

endmodule

// File: tb/tb_transmisor_adc_din.sv
// Directed bench: three transmitters (CLK_DIV=16 gated, CLK_DIV=16 ungated, CLK_DIV=1 gated).
module tb_transmisor_adc_din;

    logic iCLK;
    logic iRST_n;
    int   total;
    int   bad;

    transmisor_adc_din_if if0 ();
    transmisor_adc_din_if if1 ();
    transmisor_adc_din_if if2 ();

    transmisor_adc_din #(.CLK_DIV(16), .PEN_GATE(1'b1)) u0 (.iCLK(iCLK), .iRST_n(iRST_n), .adc_if(if0));
    transmisor_adc_din #(.CLK_DIV(16), .PEN_GATE(1'b0)) u1 (.iCLK(iCLK), .iRST_n(iRST_n), .adc_if(if1));
    transmisor_adc_din #(.CLK_DIV(1),  .PEN_GATE(1'b1)) u2 (.iCLK(iCLK), .iRST_n(iRST_n), .adc_if(if2));

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},     {31'd0, if0.adc_cs_n_s}, 32'd1);
        check({tag, "_dclk"},     {31'd0, if0.adc_dclk_s}, 32'd0);
        check({tag, "_din"},      {31'd0, if0.adc_din_s},  32'd0);
        check({tag, "_count"},    {25'd0, if0.count_80_s}, 32'd0);
        check({tag, "_trans_en"}, {31'd0, if0.trans_en_s}, 32'd0);
        check({tag, "_busy"},     {31'd0, if0.busy_s},     32'd0);
        check({tag, "_done"},     {31'd0, if0.done_s},     32'd0);
    endtask

    int         cs_low, rises, dones, done_at, busy_cnt, te_bad, max_cnt, other_ones, gate_cs;
    int         nfalls;
    int         falls[8];
    logic [7:0] xbyte, ybyte;
    logic       prev_dclk, prev_cs, found, toggled_lo, toggled_hi;

    initial begin
        total = 0;
        bad   = 0;
        iRST_n = 1'b0;
        if0.start_s = 1'b0; if0.penirq_n_s = 1'b1;
        if1.start_s = 1'b0; if1.penirq_n_s = 1'b1;
        if2.start_s = 1'b0; if2.penirq_n_s = 1'b1;

        // Reset values
        repeat (3) tick();
        check_reset_outputs("reset");
        iRST_n = 1'b1;
        tick();

        // Gating: pen up with start high; only the ungated instance starts
        if0.start_s = 1'b1;
        if1.start_s = 1'b1;
        tick();
        check("ungated_start_cs_n", {31'd0, if1.adc_cs_n_s}, 32'd0);
        if1.start_s = 1'b0;
        gate_cs = 0;
        for (int i = 0; i < 20; i++) begin
            if (if0.adc_cs_n_s == 1'b0 || if0.busy_s == 1'b1) gate_cs++;
            tick();
        end
        check("gated_no_frame", gate_cs, 32'd0);
        if0.start_s = 1'b0;
        tick();

        // Full frame, CLK_DIV=16, with pen release and start re-requests mid-frame
        if0.penirq_n_s = 1'b0;
        if0.start_s    = 1'b1;
        cs_low = 0; rises = 0; dones = 0; done_at = 0; busy_cnt = 0; te_bad = 0;
        max_cnt = 0; other_ones = 0; xbyte = 8'h00; ybyte = 8'h00; prev_dclk = 1'b0;
        for (int i = 1; i <= 1400; i++) begin
            tick();
            if (i == 1) begin
                if0.start_s = 1'b0;
                check("entry_cs_n",  {31'd0, if0.adc_cs_n_s}, 32'd0);
                check("entry_count", {25'd0, if0.count_80_s}, 32'd0);
                check("entry_dclk",  {31'd0, if0.adc_dclk_s}, 32'd0);
                check("entry_din",   {31'd0, if0.adc_din_s},  32'd1);
                check("entry_busy",  {31'd0, if0.busy_s},     32'd1);
            end
            if (i == 16) check("step0_len_count", {25'd0, if0.count_80_s}, 32'd0);
            if (i == 17) begin
                check("step1_count", {25'd0, if0.count_80_s}, 32'd1);
                check("step1_dclk",  {31'd0, if0.adc_dclk_s}, 32'd1);
            end
            if (i == 100) if0.penirq_n_s = 1'b1;
            if (i == 600) begin
                if0.penirq_n_s = 1'b0;
                if0.start_s    = 1'b1;
            end
            if (i == 610) if0.start_s = 1'b0;
            if (if0.adc_cs_n_s == 1'b0) cs_low++;
            if (if0.busy_s) busy_cnt++;
            if (if0.trans_en_s !== ~if0.adc_cs_n_s) te_bad++;
            if (int'(if0.count_80_s) > max_cnt) max_cnt = int'(if0.count_80_s);
            if (if0.done_s) begin
                dones++;
                done_at = i;
            end
            if (if0.adc_dclk_s && !prev_dclk) begin
                rises++;
                if (rises >= 1 && rises <= 8)        xbyte = {xbyte[6:0], if0.adc_din_s};
                else if (rises >= 17 && rises <= 24) ybyte = {ybyte[6:0], if0.adc_din_s};
                else if (if0.adc_din_s)              other_ones++;
            end
            prev_dclk = if0.adc_dclk_s;
        end
        check("cs_low_cycles",  cs_low,     32'd1280);
        check("dclk_rises",     rises,      32'd40);
        check("done_pulses",    dones,      32'd1);
        check("done_edge",      done_at,    32'd1281);
        check("busy_cycles",    busy_cnt,   32'd1281);
        check("trans_en_align", te_bad,     32'd0);
        check("count_max",      max_cnt,    32'd79);
        check("x_byte",         {24'd0, xbyte}, 32'h92);
        check("y_byte",         {24'd0, ybyte}, 32'hD2);
        check("din_other_zero", other_ones, 32'd0);
        check("idle_after_frame_cs_n", {31'd0, if0.adc_cs_n_s}, 32'd1);

        // Asynchronous reset at step 40 aborts the frame
        if0.penirq_n_s = 1'b0;
        if0.start_s    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if0.start_s = 1'b0;
            if (if0.count_80_s == 7'd40) found = 1'b1;
        end
        check("reached_step40", {31'd0, found}, 32'd1);
        #2;
        iRST_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        iRST_n = 1'b1;
        rises = 0; cs_low = 0; prev_dclk = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if0.adc_dclk_s && !prev_dclk) rises++;
            if (if0.adc_cs_n_s == 1'b0 || if0.busy_s) cs_low++;
            prev_dclk = if0.adc_dclk_s;
        end
        check("post_reset_no_dclk", rises,  32'd0);
        check("post_reset_idle",    cs_low, 32'd0);

        // CLK_DIV=1, start held high: 82-cycle frame period, mid-frame start toggle ignored
        if2.penirq_n_s = 1'b0;
        if2.start_s    = 1'b1;
        nfalls = 0; dones = 0; cs_low = 0; prev_cs = 1'b1;
        toggled_lo = 1'b0; toggled_hi = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (!if2.adc_cs_n_s && prev_cs && nfalls < 8) begin
                falls[nfalls] = i;
                nfalls++;
            end
            if (nfalls == 2 && !toggled_lo && if2.count_80_s == 7'd10) begin
                if2.start_s = 1'b0;
                toggled_lo  = 1'b1;
            end
            if (toggled_lo && !toggled_hi && if2.count_80_s == 7'd30) begin
                if2.start_s = 1'b1;
                toggled_hi  = 1'b1;
            end
            if (if2.done_s) dones++;
            if (!if2.adc_cs_n_s && nfalls == 1) cs_low++;
            prev_cs = if2.adc_cs_n_s;
        end
        if2.start_s = 1'b0;
        check("div1_frames", nfalls, 32'd5);
        check("div1_first_fall", falls[0], 32'd1);
        check("div1_period_1", falls[1] - falls[0], 32'd82);
        check("div1_period_2", falls[2] - falls[1], 32'd82);
        check("div1_period_3", falls[3] - falls[2], 32'd82);
        check("div1_xfer_len", cs_low, 32'd80);
        check("div1_dones",    dones,  32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
